// File: rtl/mult_pkg.sv
// Shared types and sizes for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MULT_WIDTH = 32;
    localparam int CNT_W      = $clog2(MULT_WIDTH);

endpackage

// File: rtl/seq_mult_control.sv
// Sequencer for the shift-add multiplier: FSM, iteration counter, status and
// the load/step enables that drive the datapath in the top level.
module seq_mult_control
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done,
    output logic load,
    output logic step
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    count_d = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // start is deliberately not looked at while iterating
                step    = 1'b1;
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load    = 1'b1;
                    count_d = '0;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);

endmodule

// File: rtl/seq_multiplier_32bit.sv
// Unsigned shift-add multiplier, one multiplier bit per clock; low product half
// feeds the ALU result mux, high half feeds the HI register.
module seq_multiplier_32bit
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    logic load;
    logic step;

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [WIDTH:0]     addend;
    logic [WIDTH:0]     sum;

    seq_mult_control #(
        .WIDTH (WIDTH)
    ) u_control (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy),
        .done  (done),
        .load  (load),
        .step  (step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q   <= '0;
            product_q <= '0;
        end else begin
            mcand_q   <= mcand_d;
            product_q <= product_d;
        end
    end

    // The multiplier shifts out of the low half while partial sums enter the
    // high half; the adder carry becomes the new top bit on each shift.
    always_comb begin
        mcand_d   = mcand_q;
        product_d = product_q;
        addend    = product_q[0] ? {1'b0, mcand_q} : '0;
        sum       = {1'b0, product_q[2*WIDTH-1:WIDTH]} + addend;
        if (load) begin
            mcand_d   = multiplicand;
            product_d = {{WIDTH{1'b0}}, multiplier};
        end else if (step) begin
            product_d = {sum, product_q[WIDTH-1:1]};
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier_32bit.sv
// Directed bench for seq_multiplier_32bit: a timing/arithmetic reference model
// checked every cycle, plus literal expectations for each directed operation.
module tb_seq_multiplier_32bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int vectors;
    int miscompares;

    seq_multiplier_32bit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an operation accepted at edge L is busy for the 32
    // cycles after L, strobes done after edge L+32, and the product from then
    // on equals A*B until the next accepted start.
    longint      cyc;
    longint      load_cyc;
    bit          have_load;
    logic [63:0] exp_final;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_load = 1'b0;
            exp_final = 64'd0;
        end else begin
            bit accept;
            accept = start && (!have_load || (cyc - load_cyc) >= 32);
            cyc = cyc + 1;
            if (accept) begin
                load_cyc  = cyc;
                have_load = 1'b1;
                exp_final = 64'(multiplicand) * 64'(multiplier);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        longint d;
        logic   e_busy;
        logic   e_done;
        d      = cyc - load_cyc;
        e_busy = have_load && rst_n && (d < 32);
        e_done = have_load && rst_n && (d == 32);
        chk("model_busy", 64'(busy), 64'(e_busy));
        chk("model_done", 64'(done), 64'(e_done));
        if (!have_load || d >= 32) begin
            chk("model_product", product, exp_final);
        end
    end

    // Issues one operation; optionally pulses start with junk operands at
    // iteration pulse_at. Returns the cycles to done and the busy cycle count.
    task automatic issue_and_wait(input logic [31:0] a, input logic [31:0] b,
                                  input int pulse_at,
                                  output int lat, output int busy_cnt);
        bit seen;
        @(negedge clk);
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(negedge clk);
        start        = 1'b0;
        multiplicand = 32'hDEAD_BEEF;
        multiplier   = 32'hCAFE_F00D;
        lat      = 1;
        busy_cnt = busy ? 1 : 0;
        seen     = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (lat == pulse_at) begin
                start        = 1'b1;
                multiplicand = 32'h0000_0003;
                multiplier   = 32'h0000_0005;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (busy) busy_cnt++;
            if (!done) lat++;
        end
        start = 1'b0;
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no done, expected done within 100 cycles");
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int pulse_at);
        int lat;
        int bc;
        issue_and_wait(a, b, pulse_at, lat, bc);
        chk({name, "_latency"}, 64'(lat), 64'd32);
        chk({name, "_busy_cycles"}, 64'(bc), 64'd32);
        chk({name, "_product"}, product, exp);
    endtask

    initial begin
        int lat;
        int bc;
        int gap;
        vectors      = 0;
        miscompares  = 0;
        cyc          = 0;
        load_cyc     = 0;
        have_load    = 1'b0;
        exp_final    = 64'd0;
        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = 32'd0;
        multiplier   = 32'd0;

        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_product", product, 64'd0);
        rst_n = 1'b1;

        run_op("mul_3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 0);
        repeat (3) @(negedge clk);
        chk("hold_after_idle", product, 64'h0000_0000_0000_000F);

        run_op("mul_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
        run_op("mul_msb_x2", 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 0);
        run_op("mul_zero", 32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000, 0);
        run_op("mul_7x9_pulse", 32'd7, 32'd9, 64'd63, 10);
        run_op("mul_large", 32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080, 0);

        // Asynchronous reset between edges, in the middle of a calculation.
        @(negedge clk);
        start        = 1'b1;
        multiplicand = 32'h0001_0001;
        multiplier   = 32'hFFFF_0003;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midcalc_reset_busy", 64'(busy), 64'd0);
        chk("midcalc_reset_done", 64'(done), 64'd0);
        chk("midcalc_reset_product", product, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op("mul_6x7", 32'd6, 32'd7, 64'd42, 0);

        // Back-to-back: start held through DONE reloads with no IDLE gap.
        @(negedge clk);
        start        = 1'b1;
        multiplicand = 32'd2;
        multiplier   = 32'd3;
        @(negedge clk);
        multiplicand = 32'd4;
        multiplier   = 32'd5;
        lat = 1;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (!done) lat++;
        end
        chk("b2b_first_latency", 64'(lat), 64'd32);
        chk("b2b_first_done", 64'(done), 64'd1);
        chk("b2b_first_product", product, 64'd6);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_reload_busy", 64'(busy), 64'd1);
        chk("b2b_reload_done", 64'(done), 64'd0);
        gap = 1;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            gap++;
        end
        chk("b2b_done_spacing", 64'(gap), 64'd33);
        chk("b2b_second_product", product, 64'd20);
        @(negedge clk);
        chk("b2b_done_one_cycle", 64'(done), 64'd0);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
